box_top: RTL and testbench
==========================

// Module: box_top
// PURPOSE
// - Streaming rectangle-outline overlay for 24-bit RGB video frames, 768x576 by default.
// - Pixels enter through an input FIFO write port and are processed one per cycle.
// - Pixels on the border of a programmable box are replaced by BOX_COLOR; all others pass unchanged.
// - Results leave through an output FIFO read port.
// - Sits after detection logic, which supplies the box geometry (x, y, width, height).
// PARAMETERS
// - WIDTH      768       pixels per row
// - HEIGHT     576       rows per frame
// - FIFO_DEPTH 32        entries in each of the input and output FIFOs (power of 2)
// - LINE_W     1         box line thickness in pixels
// - BOX_COLOR  24'h00FF00  replacement pixel value (green; same in BGR and RGB byte order)
// PORTS
// - clock        in   1   single clock; all logic rising-edge
// - reset        in   1   synchronous, active-high
// - x            in   10  box left column (0 = first pixel of a row)
// - y            in   10  box top row, in stream order (row 0 = first row streamed)
// - width        in   10  box width in pixels
// - height       in   10  box height in rows
// - input_full   out  1   input FIFO full; a write while full is dropped
// - input_wr_en  in   1   push input_din into the input FIFO
// - input_din    in   24  input pixel, opaque 24-bit value
// - dout_rd_en   in   1   pop the output FIFO; dout advances on the next cycle
// - dout_empty   out  1   output FIFO empty
// - dout         out  24  output pixel, FWFT: valid whenever dout_empty=0
// BEHAVIOUR
// - Reset (clock and reset only; synchronous, active-high):
//   - both FIFOs are emptied: input_full=0, dout_empty=1, dout=0;
//   - col/row counters go to 0 and the frame-geometry registers are cleared;
//   - reset mid-frame discards in-flight pixels, and the next pixel written is col 0, row 0.
// - Datapath: single-stage process step.
//   - Fires when the input FIFO is not empty and the output FIFO is not full.
//   - Pops one pixel, computes the replacement, and pushes the result in the same cycle.
//   - Otherwise stalls with no state change (backpressure).
// - Latency: a pixel written at cycle t appears on dout with dout_empty=0 no earlier than t+2 when unblocked.
// - Throughput: 1 pixel per cycle.
// - Counters: col counts 0..WIDTH-1. At col=WIDTH-1, col wraps to 0 and row increments.
//   At row=HEIGHT-1, col=WIDTH-1, both wrap to 0 (next frame). The bench holds no frame-sync signal.
// - Geometry: x, y, width and height are registered when the pixel at col 0, row 0 is processed.
//   They stay constant for the whole frame; mid-frame input changes take effect next frame.
// - Arithmetic uses 11-bit unsigned values to avoid overflow:
//   - xe = x + width - 1, ye = y + height - 1;
//   - if width=0 or height=0, no box is drawn.
// - Border pixel condition: col in [x, xe], row in [y, ye], and at least one of:
//   - col < x+LINE_W, or col > xe-LINE_W;
//   - row < y+LINE_W, or row > ye-LINE_W.
//   If the condition holds, out = BOX_COLOR; otherwise out = in.
// - Clipping: parts of the box beyond WIDTH-1 or HEIGHT-1 are simply not drawn.
//   Counters never reach those values, so no wrap-around onto the next row.
// - FIFOs:
//   - full and empty are registered flags;
//   - a simultaneous read and write when the FIFO is neither full nor empty keeps the count unchanged;
//   - a write to a full FIFO or a read from an empty FIFO is ignored.
// - The interior of the box and all pixels outside it are bit-exact copies of the input.
// - Frame size: one frame = WIDTH*HEIGHT = 442368 pixels, i.e. 1327104 bytes with no row padding.
// TESTING
// - Reset, then idle: input_full=0, dout_empty=1, and no output appears without input.
// - Full 768x576 frame of constant 24'h123456 with x=100, y=100, width=50, height=50:
//   - output is 24'h00FF00 at cols 100..149 on rows 100 and 149;
//   - output is 24'h00FF00 at rows 100..149 on cols 100 and 149;
//   - every other pixel is 24'h123456, giving exactly 196 box pixels.
// - Ramp frame (pixel = index) with width=0: output equals input bit-exact over the whole frame.
// - Box clipping with x=760, y=570, width=50, height=50, constant input:
//   - only cols 760..767 of row 570 and rows 570..575 of col 760 are coloured;
//   - no colour appears on row 571 col 0 or anywhere in the next frame's start.
// - Backpressure: hold dout_rd_en=0 until input_full=1, then read with a random 50% duty.
//   Required: no pixel is lost or duplicated, and the sequence matches the golden model.
// - Two back-to-back frames with x changed from 100 to 200 mid-frame 1:
//   - frame 1 uses x=100 throughout;
//   - frame 2 uses x=200.

Source files
------------

// File: rtl/box_top.sv
// box_top: streaming rectangle-outline overlay on 24-bit pixels, fed and drained through FWFT FIFOs.
module box_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] din,
    input  logic         rd_en,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, empty_q, wr, rd;
    assign wr    = wr_en && !full_q;
    assign rd    = rd_en && !empty_q;
    assign cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    assign full  = full_q;
    assign empty = empty_q;
    assign dout  = empty_q ? '0 : mem_q[rp_q];
    always_ff @(posedge clk) if (wr) mem_q[wp_q] <= din;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (wr) wp_q <= wp_q + AW'(1);
            if (rd) rp_q <= rp_q + AW'(1);
            cnt_q   <= cnt_d;
            full_q  <= cnt_d == (AW+1)'(DEPTH);
            empty_q <= cnt_d == '0;
        end
    end
endmodule

module box_top #(
    parameter int          WIDTH      = 768,
    parameter int          HEIGHT     = 576,
    parameter int          FIFO_DEPTH = 32,
    parameter int          LINE_W     = 1,
    parameter logic [23:0] BOX_COLOR  = 24'h00FF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [9:0]  width,
    input  logic [9:0]  height,
    output logic        input_full,
    input  logic        input_wr_en,
    input  logic [23:0] input_din,
    input  logic        dout_rd_en,
    output logic        dout_empty,
    output logic [23:0] dout
);
    localparam logic [9:0]  COL_MAX = 10'(WIDTH - 1);
    localparam logic [9:0]  ROW_MAX = 10'(HEIGHT - 1);
    localparam logic [10:0] LW      = 11'(LINE_W);
    logic        in_empty, out_full, fire, first, border;
    logic [23:0] pix, res;
    logic [9:0]  col_q, col_d, row_q, row_d;
    logic [9:0]  gx_q, gy_q, gw_q, gh_q, gx, gy, gw, gh;
    logic [10:0] c, r, xs, ys, xe, ye;
    box_fifo #(.W(24), .DEPTH(FIFO_DEPTH)) u_in (
        .clk(clock), .rst(reset), .wr_en(input_wr_en), .din(input_din), .rd_en(fire),
        .full(input_full), .empty(in_empty), .dout(pix)
    );
    box_fifo #(.W(24), .DEPTH(FIFO_DEPTH)) u_out (
        .clk(clock), .rst(reset), .wr_en(fire), .din(res), .rd_en(dout_rd_en),
        .full(out_full), .empty(dout_empty), .dout(dout)
    );
    assign fire  = !in_empty && !out_full;
    assign first = col_q == '0 && row_q == '0;
    // The first pixel of a frame already sees the geometry it latches.
    always_comb begin
        gx     = first ? x : gx_q;
        gy     = first ? y : gy_q;
        gw     = first ? width : gw_q;
        gh     = first ? height : gh_q;
        xs     = {1'b0, gx};
        ys     = {1'b0, gy};
        xe     = xs + {1'b0, gw} - 11'd1;
        ye     = ys + {1'b0, gh} - 11'd1;
        c      = {1'b0, col_q};
        r      = {1'b0, row_q};
        border = gw != '0 && gh != '0 && c >= xs && c <= xe && r >= ys && r <= ye &&
                 (c < xs + LW || c > xe - LW || r < ys + LW || r > ye - LW);
        res    = border ? BOX_COLOR : pix;
        col_d  = col_q == COL_MAX ? '0 : col_q + 10'd1;
        row_d  = col_q != COL_MAX ? row_q : (row_q == ROW_MAX ? '0 : row_q + 10'd1);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
            gx_q  <= '0;
            gy_q  <= '0;
            gw_q  <= '0;
            gh_q  <= '0;
        end else if (fire) begin
            col_q <= col_d;
            row_q <= row_d;
            if (first) begin
                gx_q <= x;
                gy_q <= y;
                gw_q <= width;
                gh_q <= height;
            end
        end
    end
endmodule

// File: tb/tb_box_top.sv
// tb_box_top: scoreboard bench for box_top on a reduced 64x48 frame.
module tb_box_top;
    localparam int W = 64;
    localparam int H = 48;
    localparam logic [23:0] BOX = 24'h00FF00;
    logic        clock = 1'b0, reset = 1'b1;
    logic [9:0]  x = '0, y = '0, width = '0, height = '0;
    logic        input_full, input_wr_en = 1'b0, dout_rd_en = 1'b0, dout_empty;
    logic [23:0] input_din = '0, dout;
    logic [23:0] sb_q [$];
    int checks = 0, fails = 0, rd_mode = 0, box_cnt = 0, mcol = 0, mrow = 0;
    int gx = 0, gy = 0, gw = 0, gh = 0;
    bit bp_hit = 0;

    box_top #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock(clock), .reset(reset), .x(x), .y(y), .width(width), .height(height),
        .input_full(input_full), .input_wr_en(input_wr_en), .input_din(input_din),
        .dout_rd_en(dout_rd_en), .dout_empty(dout_empty), .dout(dout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reader: decides rd_en at each falling edge and checks the pixel it is about to pop.
    initial forever begin
        @(negedge clock);
        dout_rd_en = rd_mode == 1 || (rd_mode == 2 && $urandom_range(0, 1) == 1);
        if (dout_rd_en && !dout_empty) begin
            if (sb_q.size() == 0) check("spurious_out", dout_empty, 1);
            else begin
                check("pixel", dout, sb_q.pop_front());
                if (dout === BOX) box_cnt++;
            end
        end
    end

    task automatic write_pixels(input int n, input bit ramp, input bit bp);
        int guard;
        logic [23:0] pix;
        bit inb;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            guard = 0;
            while (input_full) begin
                input_wr_en = 1'b0;
                if (bp && rd_mode == 0) begin
                    bp_hit  = 1;
                    rd_mode = 2;
                end
                @(negedge clock);
                guard++;
                if (guard > 5000) begin
                    fails++;
                    $display("FAIL write_timeout observed=stalled expected=accept");
                    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
                    $fatal(1, "write stalled");
                end
            end
            if (mcol == 0 && mrow == 0) begin
                gx = int'(x);
                gy = int'(y);
                gw = int'(width);
                gh = int'(height);
            end
            pix = ramp ? 24'(mrow * W + mcol) : 24'h123456;
            inb = gw > 0 && gh > 0 && mcol >= gx && mcol <= gx + gw - 1 && mrow >= gy && mrow <= gy + gh - 1;
            sb_q.push_back((inb && (mcol == gx || mcol == gx + gw - 1 || mrow == gy || mrow == gy + gh - 1)) ? BOX : pix);
            input_wr_en = 1'b1;
            input_din   = pix;
            mcol++;
            if (mcol == W) begin
                mcol = 0;
                mrow = (mrow == H - 1) ? 0 : mrow + 1;
            end
        end
        @(negedge clock);
        input_wr_en = 1'b0;
    endtask

    task automatic drain(input string tag, input int exp_box);
        int guard = 0;
        while (sb_q.size() != 0 && guard < 20000) begin
            @(negedge clock);
            guard++;
        end
        check({tag, "_drained"}, sb_q.size(), 0);
        @(negedge clock);
        check({tag, "_empty"}, dout_empty, 1);
        check({tag, "_box_cnt"}, box_cnt, exp_box);
        box_cnt = 0;
    endtask

    task automatic do_reset();
        rd_mode     = 0;
        input_wr_en = 1'b0;
        reset       = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        sb_q.delete();
        mcol    = 0;
        mrow    = 0;
        box_cnt = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_full", input_full, 0);
        check("rst_empty", dout_empty, 1);
        check("rst_dout", dout, 0);
        repeat (10) @(negedge clock);
        check("idle_empty", dout_empty, 1);
        // Single-pixel latency, then the rest of a constant frame with a 20x20 box.
        x = 10; y = 10; width = 20; height = 20;
        write_pixels(1, 0, 0);
        check("lat_t1_empty", dout_empty, 1);
        @(negedge clock);
        check("lat_t2_empty", dout_empty, 0);
        check("lat_t2_dout", dout, 24'h123456);
        rd_mode = 1;
        write_pixels(W * H - 1, 0, 0);
        drain("box", 76);
        // Clipped box at the bottom-right corner.
        x = 60; y = 44; width = 50; height = 50;
        write_pixels(W * H, 0, 0);
        drain("clip", 7);
        // Ramp with width=0: bit-exact pass-through, also covers the frame after the clip.
        x = 5; y = 5; width = 0; height = 10;
        write_pixels(W * H, 1, 0);
        drain("ramp", 0);
        // Backpressure: stall until input_full, then random 50% reads.
        x = 3; y = 2; width = 40; height = 30;
        rd_mode = 0;
        bp_hit  = 0;
        write_pixels(W * H, 1, 1);
        check("bp_full_seen", bp_hit, 1);
        drain("bp", 136);
        // Geometry change mid-frame takes effect only on the next frame.
        rd_mode = 1;
        x = 10; y = 10; width = 20; height = 20;
        write_pixels(1000, 0, 0);
        x = 30;
        write_pixels(W * H - 1000, 0, 0);
        write_pixels(W * H, 0, 0);
        drain("xchg", 152);
        // Reset mid-frame discards in-flight pixels and restarts at col 0, row 0.
        rd_mode = 0;
        write_pixels(37, 0, 0);
        do_reset();
        check("mrst_full", input_full, 0);
        check("mrst_empty", dout_empty, 1);
        check("mrst_dout", dout, 0);
        rd_mode = 1;
        x = 0; y = 0; width = W; height = H;
        write_pixels(W * H, 0, 0);
        drain("post_rst", 220);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
